sc_add_sched: RTL

Run controller for the stochastic mux-adder datapath (seeded 3-bit rotation LFSR, Sobol select generator, mux adder). It accepts one job at a time through a valid/ready handshake and loads the job's seed into the datapath. It then enables the datapath for exactly 2^LOGLEN cycles and counts the ones in the returned output bitstream. The count is the binary-domain scaled sum, returned through a valid/ready result port. It sits between the binary-domain host logic and one adder instance.

---
 rtl/sc_pkg.sv | 10 +
 rtl/sc_ones_acc.sv | 38 +++
 rtl/sc_add_sched.sv | 73 +++++++
 3 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared state type, default widths and seed remap for the stochastic adder run controller
package sc_pkg;
  localparam int SC_SEEDW = 3;
  localparam int SC_LOGLEN = 8;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} sc_sched_state_t;
  // an all-zero seed would lock the LFSR, so it is replaced by one
  function automatic int unsigned sc_seed_remap(input int unsigned s);
    return (s == 0) ? 32'd1 : s;
  endfunction
endpackage

// File: rtl/sc_ones_acc.sv
// sc_ones_acc: delays run by LAT cycles to qualify bit_in and counts the ones of the qualified stream
module sc_ones_acc #(
  parameter int LAT = 1,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         flush,
  input  logic         run,
  input  logic         bit_in,
  output logic [W-1:0] acc
);
  logic sample_en;
  generate
    if (LAT == 0) begin : g_direct
      assign sample_en = run;
    end else begin : g_pipe
      logic [LAT-1:0] sr;
      // shift run through the datapath latency; abort or a new job empties it
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else if (clear || flush) sr <= '0;
        else begin
          sr[0] <= run;
          for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
      end
      assign sample_en = sr[LAT-1];
    end
  endgenerate
  // count ones only on qualified cycles; cleared per job and discarded on abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (clear || flush) acc <= '0;
    else if (sample_en && bit_in) acc <= acc + 1'b1;
  end
endmodule

// File: rtl/sc_add_sched.sv
// sc_add_sched: one-job-at-a-time run controller that seeds, enables and counts the stochastic mux adder
module sc_add_sched import sc_pkg::*; #(
  parameter int LOGLEN = SC_LOGLEN,
  parameter int SEEDW = SC_SEEDW,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [SEEDW-1:0]  seed_in,
  input  logic              abort,
  output logic              load,
  output logic [SEEDW-1:0]  seed,
  output logic              run,
  input  logic              bit_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [LOGLEN:0]   res_data,
  output logic              busy
);
  sc_sched_state_t state, nxt;
  logic [LOGLEN-1:0] cnt;
  logic [1:0] dcnt;
  logic [SEEDW-1:0] seed_q;
  logic accept, flush;
  assign accept = (state == IDLE) && start_valid;
  assign flush = abort && (state == LOAD || state == RUN || state == DRAIN);
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state: abort only cancels while the datapath is active, a finished result always waits for its handshake
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start_valid ? LOAD : IDLE;
      LOAD:  nxt = abort ? IDLE : RUN;
      RUN:   nxt = abort ? IDLE : (&cnt) ? ((LAT > 0) ? DRAIN : DONE) : RUN;
      DRAIN: nxt = abort ? IDLE : (dcnt == 2'(LAT - 1)) ? DONE : DRAIN;
      DONE:  nxt = res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // run-length and drain counters plus the seed captured at job acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dcnt <= '0;
      seed_q <= '0;
    end else begin
      cnt <= accept ? '0 : (state == RUN) ? cnt + 1'b1 : cnt;
      dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if (accept) seed_q <= SEEDW'(sc_seed_remap(32'(seed_in)));
    end
  end
  sc_ones_acc #(.LAT(LAT), .W(LOGLEN + 1)) u_acc (
    .clk(clk),
    .rst(rst),
    .clear(accept),
    .flush(flush),
    .run(run),
    .bit_in(bit_in),
    .acc(res_data)
  );
  assign start_ready = state == IDLE;
  assign load = state == LOAD;
  assign run = state == RUN;
  assign res_valid = state == DONE;
  assign busy = state != IDLE;
  assign seed = seed_q;
endmodule
